seg_scan_multi: RTL and testbench
=================================

# seg_scan_multi

Parametrised multiplexed 7-segment display driver: holds DIGITS 4-bit hex digits plus decimal points in a writable buffer, time-multiplexes them onto one shared segment bus with a digit-select index, and optionally rotates (scrolls) the displayed content. Sits between any value-producing logic (counters, ID/status registers) and the board's segment and digit-select pins, and supersedes fixed-content single-purpose display blocks.

## Interface
- DIGITS, 3: number of multiplexed digits; 2..16.
- SCAN_DIV, 8: clock cycles each digit is held; ≥2.
- SCROLL_FRAMES, 4: full scan frames per scroll step; ≥1.
- SEL_W, $clog2(DIGITS): width of select/address buses (derived, do not override).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the digit buffer.
- wr_addr  in  SEL_W  buffer slot to write.
- wr_data  in  4  hex value 0x0..0xF.
- wr_dp  in  1  decimal point for that slot.
- blank_mask  in  DIGITS  bit p=1 forces physical digit p dark.
- scroll_en  in  1  enables rotation of displayed content.
- led  out  8  segments, active-high; bit7=dp, bits6..0 = g,f,e,d,c,b,a.
- del  out  SEL_W  currently driven physical digit index.
- frame  out  1  one-cycle pulse when del wraps DIGITS-1 → 0.

## Operation
- Buffer: DIGITS entries of {dp, hex[3:0]}; reset to all zero. wr_en with wr_addr < DIGITS writes the entry at the clock edge; wr_addr ≥ DIGITS ignored (no entry changes).
- Scan divider: counter 0..SCAN_DIV-1, free-running; tick = counter at SCAN_DIV-1.
- Select: on tick, del advances by 1, wrapping DIGITS-1 → 0; otherwise holds. frame asserted (registered) in the same cycle del becomes 0 via wrap.
- Scroll offset: 0..DIGITS-1. Frame counter counts frame pulses; on every SCROLL_FRAMES-th frame with scroll_en=1, offset increments mod DIGITS. scroll_en=0 synchronously clears offset and frame counter to 0.
- Logical digit shown on physical p: buffer[(p + offset) mod DIGITS]; mod computed without divider (compare-and-subtract).
- Decode (bits6..0): 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,A 77,b 7C,C 39,d 5E,E 79,F 71; bit7 = entry dp.
- Blank: if blank_mask[p] for the physical digit being registered into del, led = 0x00 (dp also off).
- led and del always consistent: each cycle led is registered with the decode for the select value del holds after that same edge.

## Timing
- Reset (rst sampled high): del=0, led=0x00, frame=0, divider=0, offset=0, frame counter=0, buffer cleared. First cycle after reset release: led=0x3F (digit 0 of cleared buffer), del=0.
- Digit dwell: exactly SCAN_DIV cycles per del value; full frame DIGITS×SCAN_DIV cycles.
- Write latency: wr_en sampled at edge t updates buffer at t; led reflects new value at edge t+1 if that digit is selected (or when next selected).
- Write to the slot currently displayed while tick occurs: buffer updates, led shows the newly selected digit; new value seen when that slot next displayed.
- Offset change coincides with the frame wrap edge; the digit-0 slot of the new frame already uses the new offset.
- blank_mask is sampled every cycle, same 1-cycle latency as writes.
- rst mid-frame: all state returns to reset values on that edge regardless of wr_en/tick; a simultaneous write is discarded.

## Test plan
- Defaults; write slots 0,1,2 = 1,0,9; free-run → led 0x06/0x3F/0x6F with del 0/1/2, each held 8 cycles, frame pulse every 24 cycles.
- Write hex A–F plus dp to slot 1 across frames → led at del=1 = 0xF7,0xFC,0xB9,0xDE,0xF9,0xF1 (dp bit set).
- Buffer 1,0,9, scroll_en=1, SCROLL_FRAMES=4 → after 4 frames del 0/1/2 show 0x3F/0x6F/0x06; after 8 frames 0x6F/0x06/0x3F; deassert scroll_en → returns to 0x06/0x3F/0x6F next cycle.
- blank_mask=3'b010 → led=0x00 while del=1, other digits unaffected; clear mask → 0x3F at del=1 one cycle later.
- wr_addr=3 with DIGITS=3 → no buffer change; DIGITS=4 build cycles del 0..3.
- Assert rst mid-frame with wr_en active → del=0, led=0x00, frame=0, then 0x3F on all digits; write ignored.

Source files
------------

// File: rtl/seg_scan_multi_if.sv
// Write port, display controls and multiplexed segment/select outputs of seg_scan_multi.
// Parameterise DIGITS identically on the interface and on the driver instance.
interface seg_scan_multi_if #(
  parameter int DIGITS = 3
) ();
  localparam int SEL_W = $clog2(DIGITS);

  logic              wr_en;
  logic [SEL_W-1:0]  wr_addr;
  logic [3:0]        wr_data;
  logic              wr_dp;
  logic [DIGITS-1:0] blank_mask;
  logic              scroll_en;
  logic [7:0]        led;
  logic [SEL_W-1:0]  del;
  logic              frame;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, blank_mask, scroll_en,
    input  led, del, frame
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, blank_mask, scroll_en,
    output led, del, frame
  );
endinterface

// File: rtl/seg_scan_multi.sv
// Multiplexed, optionally scrolling 7-segment driver for DIGITS hex digits with decimal points.
// led/del/frame are registered together; writes and blank_mask reach led one cycle after sampling; no backpressure.
module seg_scan_multi #(
  parameter int DIGITS        = 3,
  parameter int SCAN_DIV      = 8,
  parameter int SCROLL_FRAMES = 4
) (
  input logic            clk,
  input logic            rst,
  seg_scan_multi_if.slave bus
);
  localparam int SEL_W = $clog2(DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FC_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);
  localparam logic [SEL_W:0]   DIGITS_W = (SEL_W + 1)'(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SCROLL_FRAMES - 1);

  logic [4:0]        r_buf [DIGITS];
  logic [DIGITS-1:0] r_blank;
  logic [DIV_W-1:0]  r_div;
  logic [SEL_W-1:0]  r_del;
  logic [SEL_W-1:0]  r_off;
  logic [FC_W-1:0]   r_fcnt;
  logic [7:0]        r_led;
  logic              r_frame;

  logic              w_tick;
  logic              w_wrap;
  logic              w_wr_ok;
  logic [SEL_W-1:0]  w_del_nx;
  logic [SEL_W-1:0]  w_off_nx;
  logic [FC_W-1:0]   w_fcnt_nx;
  logic [SEL_W:0]    w_sum;
  logic [SEL_W-1:0]  w_slot;
  logic [4:0]        w_entry;
  logic [7:0]        w_led_nx;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign w_tick  = (r_div == DIV_LAST);
  assign w_wrap  = w_tick && (r_del == LAST_SEL);
  assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < DIGITS_W);

  always_comb begin
    w_del_nx = r_del;
    if (w_tick) begin
      w_del_nx = (r_del == LAST_SEL) ? '0 : r_del + 1'b1;
    end
  end

  // Offset moves on the wrap edge itself so digit 0 of the new frame already uses it.
  always_comb begin
    w_off_nx  = r_off;
    w_fcnt_nx = r_fcnt;
    if (!bus.scroll_en) begin
      w_off_nx  = '0;
      w_fcnt_nx = '0;
    end else if (w_wrap) begin
      if (r_fcnt == FC_LAST) begin
        w_fcnt_nx = '0;
        w_off_nx  = (r_off == LAST_SEL) ? '0 : r_off + 1'b1;
      end else begin
        w_fcnt_nx = r_fcnt + 1'b1;
      end
    end
  end

  // Both operands are below DIGITS, so a single conditional subtract gives the modulo.
  always_comb begin
    w_sum  = {1'b0, w_del_nx} + {1'b0, w_off_nx};
    w_slot = w_sum[SEL_W-1:0];
    if (w_sum >= DIGITS_W) begin
      w_slot = SEL_W'(w_sum - DIGITS_W);
    end
    w_entry  = r_buf[w_slot];
    w_led_nx = r_blank[w_del_nx] ? 8'h00 : {w_entry[4], seg7(w_entry[3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_del   <= '0;
      r_off   <= '0;
      r_fcnt  <= '0;
      r_led   <= 8'h00;
      r_frame <= 1'b0;
      r_blank <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_del   <= w_del_nx;
      r_off   <= w_off_nx;
      r_fcnt  <= w_fcnt_nx;
      r_led   <= w_led_nx;
      r_frame <= w_wrap;
      r_blank <= bus.blank_mask;
      if (w_wr_ok) begin
        r_buf[bus.wr_addr] <= {bus.wr_dp, bus.wr_data};
      end
    end
  end

  assign bus.led   = r_led;
  assign bus.del   = r_del;
  assign bus.frame = r_frame;
endmodule

// File: tb/tb_seg_scan_multi.sv
// Bench for seg_scan_multi: a 3-digit and a 4-digit instance share one stimulus stream,
// checked every cycle against a time-based model plus hand-computed literal expectations.
module tb_seg_scan_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       scroll_en;
  logic [3:0] blank_mask;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  seg_scan_multi_if #(.DIGITS(3)) bus0 ();
  seg_scan_multi_if #(.DIGITS(4)) bus1 ();

  assign bus0.wr_en      = wr_en;
  assign bus0.wr_addr    = wr_addr;
  assign bus0.wr_data    = wr_data;
  assign bus0.wr_dp      = wr_dp;
  assign bus0.blank_mask = blank_mask[2:0];
  assign bus0.scroll_en  = scroll_en;
  assign bus1.wr_en      = wr_en;
  assign bus1.wr_addr    = wr_addr;
  assign bus1.wr_data    = wr_data;
  assign bus1.wr_dp      = wr_dp;
  assign bus1.blank_mask = blank_mask;
  assign bus1.scroll_en  = scroll_en;

  seg_scan_multi #(.DIGITS(3), .SCAN_DIV(8), .SCROLL_FRAMES(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  seg_scan_multi #(.DIGITS(4), .SCAN_DIV(2), .SCROLL_FRAMES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Model: position in the scan follows directly from cycles since reset.
  int         p_d  [2] = '{3, 4};
  int         p_sd [2] = '{8, 2};
  int         p_sf [2] = '{4, 1};
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         m_cyc [2];
  int         m_nw  [2];
  logic [3:0] m_blank [2];
  logic [4:0] m_buf [2][16];
  logic [7:0] e_led [2];
  int         e_del [2];
  logic       e_frame [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    int d, sd, sf, slot;
    for (int k = 0; k < 2; k++) begin
      d  = p_d[k];
      sd = p_sd[k];
      sf = p_sf[k];
      if (rst) begin
        m_cyc[k]   = 0;
        m_nw[k]    = 0;
        m_blank[k] = '0;
        for (int i = 0; i < 16; i++) m_buf[k][i] = '0;
        e_led[k]   = 8'h00;
        e_del[k]   = 0;
        e_frame[k] = 1'b0;
      end else begin
        m_cyc[k]++;
        e_del[k]   = (m_cyc[k] / sd) % d;
        e_frame[k] = (m_cyc[k] % (sd * d)) == 0;
        if (!scroll_en) m_nw[k] = 0;
        else if (e_frame[k]) m_nw[k]++;
        slot = (e_del[k] + (m_nw[k] / sf) % d) % d;
        e_led[k] = m_blank[k][e_del[k]] ? 8'h00 : {m_buf[k][slot][4], seg_tab[m_buf[k][slot][3:0]]};
        if (wr_en && int'(wr_addr) < d) m_buf[k][wr_addr] = {wr_dp, wr_data};
        m_blank[k] = blank_mask & 4'((1 << d) - 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_led0",   bus0.led,   e_led[0]);
      check("cyc_del0",   bus0.del,   e_del[0]);
      check("cyc_frame0", bus0.frame, e_frame[0]);
      check("cyc_led1",   bus1.led,   e_led[1]);
      check("cyc_del1",   bus1.del,   e_del[1]);
      check("cyc_frame1", bus1.frame, e_frame[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] v, input logic dp);
    step();
    wr_en = 1'b1; wr_addr = a; wr_data = v; wr_dp = dp;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_del(input int d);
    int n = 0;
    @(negedge clk);
    while (int'(bus0.del) != d && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_del_timeout", bus0.del, d);
  endtask

  task automatic wait_frames(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus0.frame) seen++;
    end
    if (seen < n) check("wait_frames_timeout", seen, n);
  endtask

  logic [7:0] hex_exp [6] = '{8'hF7, 8'hFC, 8'hB9, 8'hDE, 8'hF9, 8'hF1};

  initial begin : stim
    int per, dwell, n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
    scroll_en = 1'b0; blank_mask = '0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_led",   bus0.led,   8'h00);
    check("rst_del",   bus0.del,   0);
    check("rst_frame", bus0.frame, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rel_led", bus0.led, 8'h3F);
    check("rel_del", bus0.del, 0);

    wr(2'd0, 4'h1, 1'b0);
    wr(2'd1, 4'h0, 1'b0);
    wr(2'd2, 4'h9, 1'b0);
    wait_del(1); check("base_d1", bus0.led, 8'h3F);
    wait_del(2); check("base_d2", bus0.led, 8'h6F);
    wait_del(0); check("base_d0", bus0.led, 8'h06);
    check("base_frame", bus0.frame, 1);
    per = 0; dwell = 0;
    do begin
      @(negedge clk);
      per++;
      if (dwell == 0 && bus0.del != 0) dwell = per;
    end while (!bus0.frame && per < 100);
    check("dwell", dwell, 8);
    check("frame_period", per, 24);

    for (int i = 0; i < 6; i++) begin
      wr(2'd1, 4'(10 + i), 1'b1);
      wait_del(0);
      wait_del(1);
      check("hex_dp", bus0.led, hex_exp[i]);
    end
    wr(2'd1, 4'h0, 1'b0);

    wait_del(1);
    step();
    scroll_en = 1'b1;
    wait_frames(4); check("scr4_d0", bus0.led, 8'h3F);
    wait_del(1);    check("scr4_d1", bus0.led, 8'h6F);
    wait_del(2);    check("scr4_d2", bus0.led, 8'h06);
    wait_frames(4); check("scr8_d0", bus0.led, 8'h6F);
    wait_del(1);    check("scr8_d1", bus0.led, 8'h06);
    wait_del(2);    check("scr8_d2", bus0.led, 8'h3F);
    step();
    scroll_en = 1'b0;
    step();
    @(negedge clk);
    check("scr_off_d2", bus0.led, 8'h6F);

    wait_del(2);
    step();
    blank_mask = 4'b0010;
    wait_del(0); check("blank_d0", bus0.led, 8'h06);
    wait_del(1); check("blank_d1", bus0.led, 8'h00);
    step();
    blank_mask = 4'b0000;
    step();
    @(negedge clk); check("blank_hold", bus0.led, 8'h00);
    @(negedge clk); check("blank_clr",  bus0.led, 8'h3F);

    wr(2'd3, 4'h5, 1'b0);
    wait_del(0); check("a3_d0", bus0.led, 8'h06);
    wait_del(1); check("a3_d1", bus0.led, 8'h3F);
    wait_del(2); check("a3_d2", bus0.led, 8'h6F);
    n = 0;
    while (bus1.del != 2'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d4_slot3", bus1.led, 8'h6D);

    wait_del(1);
    step();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h7; wr_dp = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0; wr_dp = 1'b0;
    @(negedge clk);
    check("mrst_del",   bus0.del,   0);
    check("mrst_led",   bus0.led,   8'h00);
    check("mrst_frame", bus0.frame, 0);
    wait_del(1); check("mrst_d1", bus0.led, 8'h3F);
    wait_del(2); check("mrst_d2", bus0.led, 8'h3F);
    wait_del(0); check("mrst_d0", bus0.led, 8'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
